// File: rtl/hi_reader_corr_param.sv
// hi_reader_corr_param
//   Reader-side HF I/Q subcarrier correlator. ADC samples are correlated over a
//   2**WIN_LOG2 sample window against I and Q square references at a selectable
//   subcarrier rate. Once per window the result (I/Q or amplitude, with optional
//   reader-bit tagging for sniffing) is latched and serialized to the ARM over SSP.
//   All state changes on the falling edge of ck_1356meg.
// Ports
//   ck_1356meg           13.56 MHz clock
//   reset                asynchronous, active-high
//   adc_d                unsigned ADC sample
//   subcarrier_frequency 0:848k 1:424k 2:212k 3:106k
//   out_mode             0:IQ 1:amplitude 2:sniff IQ 3:sniff amplitude
//   adc_clk              ADC clock (= ck_1356meg)
//   corr_i / corr_q      latched result words
//   out_valid            one-cycle pulse when corr_i/corr_q update
//   reader_bit           hysteresis reader-modulation bit
//   ssp_clk/frame/din    serial link to the ARM, MSB first
module hi_reader_corr_param #(
    parameter int ADC_W    = 8,
    parameter int WIN_LOG2 = 6,
    parameter int ACC_W    = 14,
    parameter int OUT_W    = 8,
    parameter int IQ_SHIFT = 4,
    parameter int HYST_TO  = 4095
) (
    input  logic             ck_1356meg,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_d,
    input  logic [1:0]       subcarrier_frequency,
    input  logic [1:0]       out_mode,
    output logic             adc_clk,
    output logic [OUT_W-1:0] corr_i,
    output logic [OUT_W-1:0] corr_q,
    output logic             out_valid,
    output logic             reader_bit,
    output logic             ssp_clk,
    output logic             ssp_frame,
    output logic             ssp_din
);

    localparam int LOW_W = $clog2(HYST_TO + 1);
    localparam logic [WIN_LOG2-1:0] CNT_ZERO = '0;
    localparam logic [WIN_LOG2-1:0] CNT_ONE  = WIN_LOG2'(1);
    localparam logic [WIN_LOG2-1:0] CNT_3    = WIN_LOG2'(3);
    localparam logic [WIN_LOG2-1:0] CNT_HALF = WIN_LOG2'(2 ** (WIN_LOG2 - 1));
    localparam logic [LOW_W-1:0]    LOW_LAST = LOW_W'(HYST_TO - 1);

    logic [WIN_LOG2-1:0]     cnt;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic signed [ACC_W-1:0] samp;
    logic                    primed;     // a full window has been accumulated since reset
    logic                    rb_s0, rb_s32;
    logic [LOW_W-1:0]        low_cnt;
    logic [2*OUT_W-1:0]      shift;

    logic [WIN_LOG2-1:0]     cnt_k, cnt_k1;
    logic                    i_ref, q_ref;
    logic [ACC_W-1:0]        abs_i, abs_q, amp_max, amp_min, amp;
    logic signed [ACC_W-1:0] sh_i0, sh_q0, sh_i1, sh_q1;
    logic [OUT_W-1:0]        s2_i, s2_q;
    logic [OUT_W-1:0]        nxt_i, nxt_q, ld_i, ld_q;
    logic                    latch;
    logic                    rb_nxt;
    logic [LOW_W-1:0]        low_nxt;

    // Reference bit index: 3 + rate select, clamped so it stays inside cnt.
    function automatic int ref_k(input logic [1:0] f);
        int k;
        k = 3 + int'(f);
        if (k > WIN_LOG2 - 1) k = WIN_LOG2 - 1;
        return k;
    endfunction

    // Signed saturation of v to w bits, returned right-aligned in OUT_W bits.
    function automatic logic [OUT_W-1:0] sat_to(input logic signed [ACC_W-1:0] v, input int w);
        logic signed [ACC_W-1:0] hi, lo;
        hi = ACC_W'((1 <<< (w - 1)) - 1);
        lo = -hi - 1;
        if (v > hi)      return hi[OUT_W-1:0];
        else if (v < lo) return lo[OUT_W-1:0];
        else             return v[OUT_W-1:0];
    endfunction

    assign adc_clk = ck_1356meg;
    assign samp    = signed'({{(ACC_W-ADC_W){1'b0}}, adc_d});
    assign ssp_din = shift[2*OUT_W-1];
    assign latch   = (cnt == CNT_ZERO) && primed;

    always_comb begin
        cnt_k  = cnt >> ref_k(subcarrier_frequency);
        cnt_k1 = cnt >> (ref_k(subcarrier_frequency) - 1);
        i_ref  = ~cnt_k[0];
        q_ref  = ~(cnt_k[0] ^ cnt_k1[0]);
    end

    // Amplitude estimate max + min/2 on the finished accumulators.
    always_comb begin
        abs_i = acc_i[ACC_W-1] ? -acc_i : acc_i;
        abs_q = acc_q[ACC_W-1] ? -acc_q : acc_q;
        if (abs_i >= abs_q) begin
            amp_max = abs_i;
            amp_min = abs_q;
        end else begin
            amp_max = abs_q;
            amp_min = abs_i;
        end
        amp = amp_max + (amp_min >> 1);
    end

    always_comb begin
        sh_i0 = acc_i >>> IQ_SHIFT;
        sh_q0 = acc_q >>> IQ_SHIFT;
        sh_i1 = acc_i >>> (IQ_SHIFT + 1);
        sh_q1 = acc_q >>> (IQ_SHIFT + 1);
        s2_i  = sat_to(sh_i1, OUT_W - 1);
        s2_q  = sat_to(sh_q1, OUT_W - 1);
        nxt_i = corr_i;
        nxt_q = corr_q;
        case (out_mode)
            2'd0: begin
                nxt_i = sat_to(sh_i0, OUT_W);
                nxt_q = sat_to(sh_q0, OUT_W);
            end
            2'd1: {nxt_i, nxt_q} = {{(2*OUT_W-ACC_W){1'b0}}, amp};
            2'd2: begin
                nxt_i = {s2_i[OUT_W-2:0], rb_s0};
                nxt_q = {s2_q[OUT_W-2:0], rb_s32};
            end
            default: {nxt_i, nxt_q} = {amp[ACC_W-1 -: 2*OUT_W-2], rb_s0, rb_s32};
        endcase
        // The serializer always carries what corr_i/corr_q hold after this edge.
        ld_i = latch ? nxt_i : corr_i;
        ld_q = latch ? nxt_q : corr_q;
    end

    // Reader-bit hysteresis: the timeout release wins over the sample rule so a
    // carrier held low cannot pin the bit at 0.
    always_comb begin
        rb_nxt  = reader_bit;
        low_nxt = low_cnt;
        if (!reader_bit && (low_cnt == LOW_LAST)) begin
            rb_nxt  = 1'b1;
            low_nxt = '0;
        end else begin
            if (&adc_d)       rb_nxt = 1'b1;
            else if (~|adc_d) rb_nxt = 1'b0;
            low_nxt = reader_bit ? '0 : low_cnt + 1'b1;
        end
    end

    always_ff @(negedge ck_1356meg or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            corr_i     <= '0;
            corr_q     <= '0;
            out_valid  <= 1'b0;
            primed     <= 1'b0;
            rb_s0      <= 1'b0;
            rb_s32     <= 1'b0;
            reader_bit <= 1'b1;
            low_cnt    <= '0;
            ssp_clk    <= 1'b0;
            ssp_frame  <= 1'b0;
            shift      <= '0;
        end else begin
            cnt       <= cnt + 1'b1;
            out_valid <= latch;
            if (latch) begin
                corr_i <= nxt_i;
                corr_q <= nxt_q;
            end
            if (cnt == CNT_ZERO) begin
                acc_i  <= samp;
                acc_q  <= samp;
                primed <= 1'b1;
                rb_s0  <= reader_bit;
                shift  <= {ld_i, ld_q};
            end else begin
                acc_i <= i_ref ? acc_i + samp : acc_i - samp;
                acc_q <= q_ref ? acc_q + samp : acc_q - samp;
                if (cnt[1:0] == 2'd0) shift <= {shift[2*OUT_W-2:0], 1'b0};
            end
            if (cnt == CNT_HALF) rb_s32 <= reader_bit;
            reader_bit <= rb_nxt;
            low_cnt    <= low_nxt;
            if (cnt[1:0] == 2'd0)      ssp_clk <= 1'b1;
            else if (cnt[1:0] == 2'd2) ssp_clk <= 1'b0;
            if (cnt == CNT_ONE)        ssp_frame <= 1'b1;
            else if (cnt == CNT_3)     ssp_frame <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hi_reader_corr_param.sv
// Bench for hi_reader_corr_param: directed windows from known patterns, a
// randomized phase, hysteresis timeout, and a mid-window reset. A window-level
// reference model recomputes each correlation from the stored samples.
module tb_hi_reader_corr_param;

    localparam int HYST_TO = 4095;

    logic       ck_1356meg;
    logic       reset;
    logic [7:0] adc_d;
    logic [1:0] subcarrier_frequency;
    logic [1:0] out_mode;
    logic       adc_clk;
    logic [7:0] corr_i, corr_q;
    logic       out_valid, reader_bit, ssp_clk, ssp_frame, ssp_din;

    hi_reader_corr_param dut (
        .ck_1356meg(ck_1356meg),
        .reset(reset),
        .adc_d(adc_d),
        .subcarrier_frequency(subcarrier_frequency),
        .out_mode(out_mode),
        .adc_clk(adc_clk),
        .corr_i(corr_i),
        .corr_q(corr_q),
        .out_valid(out_valid),
        .reader_bit(reader_bit),
        .ssp_clk(ssp_clk),
        .ssp_frame(ssp_frame),
        .ssp_din(ssp_din)
    );

    // clock / reset
    initial ck_1356meg = 1'b0;
    always #5 ck_1356meg = ~ck_1356meg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] cur_freq = 2'd0;
    logic [1:0] cur_mode = 2'd0;

    // reference model state
    int   m_cnt, m_last_c, m_low;
    bit   m_primed, m_edge_seen, m_rb, m_rb0, m_rb32;
    int   ws[64];
    int   wk[64];
    int   e_i, e_q;
    bit   e_valid;
    logic [15:0] exp_q[$];

    // serial monitor state
    bit         prev_clk, prev_frame, prev_din, collecting;
    int         nbits;
    logic [15:0] word_acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap14(input int v);
        int r;
        r = v & 16383;
        if (r >= 8192) r = r - 16384;
        return r;
    endfunction

    function automatic int sat(input int v, input int w);
        int hi;
        hi = (1 << (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    function automatic int k_of(input int f);
        return (3 + f > 5) ? 5 : 3 + f;
    endfunction

    function automatic int pat_val(input int p, input int c);
        int r;
        case (p)
            0: return 128;
            1: return ((c >> 3) & 1) ? 56 : 200;
            2: return ((c >> 3) & 1) ? 120 : 136;
            3: return $urandom_range(0, 255);
            4: begin
                r = $urandom_range(0, 15);
                if (r == 0) return 0;
                if (r == 1) return 255;
                return $urandom_range(1, 254);
            end
            5: return 0;
            default: return 255;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_last_c = 0; m_low = 0;
        m_primed = 0; m_edge_seen = 0; m_rb = 1; m_rb0 = 0; m_rb32 = 0;
        e_i = 0; e_q = 0; e_valid = 0;
        exp_q.delete();
        prev_clk = 0; prev_frame = 0; prev_din = 0; collecting = 0; nbits = 0; word_acc = '0;
    endtask

    // Correlate the finished window and form the result for the given mode.
    task automatic model_latch(input int mode);
        int ai, aq, s, k, bi, bq, a, b, mx, mn, w;
        ai = 0; aq = 0;
        for (int n = 0; n < 64; n++) begin
            s = ws[n]; k = wk[n];
            bi = (n >> k) & 1;
            bq = ((n >> k) ^ (n >> (k - 1))) & 1;
            if (n == 0) begin
                ai += s; aq += s;
            end else begin
                ai += bi ? -s : s;
                aq += bq ? -s : s;
            end
        end
        ai = wrap14(ai); aq = wrap14(aq);
        a = (ai < 0) ? -ai : ai;
        b = (aq < 0) ? -aq : aq;
        mx = (a >= b) ? a : b;
        mn = (a >= b) ? b : a;
        w = (mx + (mn >> 1)) & 16383;
        case (mode)
            0: begin e_i = sat(ai >>> 4, 8) & 255; e_q = sat(aq >>> 4, 8) & 255; end
            1: begin e_i = (w >> 8) & 255; e_q = w & 255; end
            2: begin
                e_i = ((sat(ai >>> 5, 7) & 127) << 1) | int'(m_rb0);
                e_q = ((sat(aq >>> 5, 7) & 127) << 1) | int'(m_rb32);
            end
            default: begin
                w = (w << 2) | (int'(m_rb0) << 1) | int'(m_rb32);
                e_i = (w >> 8) & 255; e_q = w & 255;
            end
        endcase
        e_valid = 1;
    endtask

    // One falling edge of the design, as seen by the model.
    task automatic model_edge(input int adc, input int f, input int mode);
        int c;
        bit nrb;
        c = m_cnt;
        e_valid = 0;
        if (c == 0) begin
            if (m_primed) model_latch(mode);
            exp_q.push_back(16'((e_i << 8) | e_q));
            m_primed = 1;
            m_rb0 = m_rb;
        end
        if (c == 32) m_rb32 = m_rb;
        ws[c] = adc;
        wk[c] = k_of(f);
        if (!m_rb && (m_low == HYST_TO - 1)) begin
            m_rb = 1; m_low = 0;
        end else begin
            nrb = m_rb;
            if (adc == 255) nrb = 1;
            else if (adc == 0) nrb = 0;
            m_low = m_rb ? 0 : m_low + 1;
            m_rb = nrb;
        end
        m_last_c = c;
        m_edge_seen = 1;
        m_cnt = (c + 1) % 64;
    endtask

    task automatic compare_all();
        bit ec, ef;
        logic [15:0] w;
        ec = m_edge_seen && ((m_last_c % 4) < 2);
        ef = m_edge_seen && (m_last_c == 1 || m_last_c == 2);
        check_eq("out_valid", out_valid, e_valid);
        check_eq("corr_i", corr_i, e_i);
        check_eq("corr_q", corr_q, e_q);
        check_eq("reader_bit", reader_bit, m_rb);
        check_eq("ssp_clk", ssp_clk, ec);
        check_eq("ssp_frame", ssp_frame, ef);
        if (collecting && ssp_clk && !prev_clk) begin
            word_acc = {word_acc[14:0], prev_din};
            nbits++;
            if (nbits == 16) begin
                check_eq("ssp_word_avail", exp_q.size() > 0, 1);
                w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
                check_eq("ssp_word", word_acc, w);
                collecting = 0;
            end
        end
        if (ssp_frame && !prev_frame) begin
            collecting = 1; nbits = 0; word_acc = '0;
        end
        prev_clk = ssp_clk; prev_frame = ssp_frame; prev_din = ssp_din;
    endtask

    // driver: check the previous edge, then drive and model the next one
    task automatic tick(input int p);
        int v;
        @(posedge ck_1356meg); #1;
        compare_all();
        v = pat_val(p, m_cnt);
        adc_d = 8'(v);
        subcarrier_frequency = cur_freq;
        out_mode = cur_mode;
        model_edge(v, int'(cur_freq), int'(cur_mode));
    endtask

    // run until nw more window-start edges have been driven
    task automatic latch_after(input int p, input int nw);
        repeat (nw) begin
            do tick(p); while (m_cnt != 1);
        end
    endtask

    task automatic after_edge();
        @(negedge ck_1356meg); #1;
    endtask

    initial begin
        int chg, idx;
        reset = 1'b1; adc_d = '0; subcarrier_frequency = '0; out_mode = '0;
        model_reset();
        repeat (3) @(posedge ck_1356meg);
        #1;
        check_eq("rst_corr_i", corr_i, 0);
        check_eq("rst_corr_q", corr_q, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_rb", reader_bit, 1);
        check_eq("rst_ssp", {ssp_clk, ssp_frame, ssp_din}, 0);
        check_eq("adc_clk", adc_clk, ck_1356meg);
        @(negedge ck_1356meg); #2;
        reset = 1'b0;

        // directed windows
        latch_after(0, 3);
        after_edge();
        check_eq("dir128_i", corr_i, 8'h00);
        check_eq("dir128_q", corr_q, 8'h00);
        check_eq("dir128_valid", out_valid, 1);
        latch_after(1, 2);
        after_edge();
        check_eq("dir200_i", corr_i, 8'h7f);
        check_eq("dir200_q", corr_q, 8'h00);
        cur_mode = 2'd1;
        latch_after(1, 1);
        after_edge();
        check_eq("amp_i", corr_i, 8'h12);
        check_eq("amp_q", corr_q, 8'h00);
        cur_mode = 2'd0;
        latch_after(2, 2);
        after_edge();
        check_eq("dir136_i", corr_i, 8'h20);
        check_eq("dir136_q", corr_q, 8'h00);
        cur_freq = 2'd1;
        latch_after(1, 2);
        after_edge();
        check_eq("freq1_i", corr_i, 8'h00);

        // randomized windows, with occasional mid-window rate changes
        repeat (24) begin
            cur_mode = 2'($urandom_range(0, 3));
            cur_freq = 2'($urandom_range(0, 3));
            chg = $urandom_range(1, 120);
            idx = 0;
            do begin
                tick(4);
                idx++;
                if (idx == chg) cur_freq = 2'($urandom_range(0, 3));
            end while (m_cnt != 1);
        end

        // hysteresis timeout
        cur_mode = 2'd2;
        tick(6);
        tick(5);
        after_edge();
        check_eq("rb_fall", reader_bit, 0);
        repeat (HYST_TO - 1) tick(5);
        after_edge();
        check_eq("rb_hold", reader_bit, 0);
        tick(5);
        after_edge();
        check_eq("rb_timeout", reader_bit, 1);
        repeat (10) tick(5);
        tick(6);
        after_edge();
        check_eq("rb_set", reader_bit, 1);
        cur_mode = 2'd3;
        latch_after(4, 3);

        // mid-window reset
        cur_mode = 2'd0; cur_freq = 2'd0;
        latch_after(3, 2);
        while (m_cnt != 37) tick(3);
        @(posedge ck_1356meg); #1;
        reset = 1'b1;
        #1;
        check_eq("mrst_corr_i", corr_i, 0);
        check_eq("mrst_corr_q", corr_q, 0);
        check_eq("mrst_valid", out_valid, 0);
        check_eq("mrst_rb", reader_bit, 1);
        check_eq("mrst_ssp", {ssp_clk, ssp_frame, ssp_din}, 0);
        model_reset();
        @(negedge ck_1356meg);
        @(negedge ck_1356meg); #2;
        reset = 1'b0;
        latch_after(1, 1);
        after_edge();
        check_eq("post_rst_no_valid", out_valid, 0);
        latch_after(1, 1);
        after_edge();
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_i", corr_i, 8'h7f);
        latch_after(4, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
